// File: rtl/zone_stat_rd.sv
// zone_stat_rd
// Reads back one finished page of the block-row buffer, unpacks each 48-bit
// word into six 8-bit gray pixels and produces per-zone max and sum for one
// row of backlight zones.
//
// Ports
//   i_pix_clk   clock
//   rst_n       asynchronous active-low reset
//   page_sel    writer page flag (rise = page 0 done, fall = page 1 done)
//   rd_ready    memory accepts a request this cycle
//   rd_valid    rd_data valid (in request order, latency >= 1)
//   rd_data     six packed pixels, [47:40] first
//   rd_en       read request strobe
//   rd_addr     read word address
//   busy        pass in progress
//   zone_valid  one-cycle strobe, zone_idx/zone_max/zone_sum valid
//   zone_idx    zone number
//   zone_max    max pixel in the zone
//   zone_sum    sum of the zone's pixels
//   row_done    one-cycle strobe with the last zone of the pass
//   err_ovr     one-cycle strobe: page_sel edge arrived while busy
//   dbg_state   current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
//
// Handshake: a request is issued as a registered rd_en/rd_addr pair one
// cycle after a cycle in which rd_ready=1 was seen in ISSUE; every rd_valid
// cycle delivers exactly one word, in request order, and is never back-
// pressured.
module zone_stat_rd #(
  parameter int PAGE0_BASE = 1,
  parameter int PAGE1_BASE = 11449,
  parameter int ZONES_X    = 26,
  parameter int ZONE_H     = 9,
  parameter int WPZ        = 8,
  parameter int WPL        = 208
) (
  input  logic        i_pix_clk,
  input  logic        rst_n,
  input  logic        page_sel,
  input  logic        rd_ready,
  input  logic        rd_valid,
  input  logic [47:0] rd_data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  output logic        busy,
  output logic        zone_valid,
  output logic [4:0]  zone_idx,
  output logic [7:0]  zone_max,
  output logic [16:0] zone_sum,
  output logic        row_done,
  output logic        err_ovr,
  output logic [1:0]  dbg_state
);

  localparam int WW = (WPZ > 1) ? $clog2(WPZ) : 1;
  localparam int LW = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;
  localparam logic [15:0] WPL16 = 16'(WPL);
  localparam logic [15:0] WPZ16 = 16'(WPZ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  // Edge detect; the register is loaded from the live input during reset so
  // that leaving reset never looks like a page flip.
  logic page_sel_q;
  logic pg_edge;
  assign pg_edge = page_sel_q ^ page_sel;

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) page_sel_q <= page_sel;
    else        page_sel_q <= page_sel;
  end

  // Request side
  logic [15:0]   base_q;
  logic [WW-1:0] iss_w;
  logic [LW-1:0] iss_l;
  logic [4:0]    iss_z;
  logic          iss_last;
  logic          issue_fire;
  logic [15:0]   addr_calc;

  assign issue_fire = (state == ISSUE) && rd_ready;
  assign iss_last   = (iss_z == 5'(ZONES_X - 1)) && (iss_l == LW'(ZONE_H - 1)) &&
                      (iss_w == WW'(WPZ - 1));
  assign addr_calc  = base_q + 16'(iss_l) * WPL16 + 16'(iss_z) * WPZ16 + 16'(iss_w);

  // FSM
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pg_edge) state_nx = ISSUE;
      ISSUE:   if (issue_fire && iss_last) state_nx = DRAIN;
      DRAIN:   if (row_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      err_ovr <= 1'b0;
    end else begin
      // An edge while busy (including the row_done cycle) is dropped.
      err_ovr <= pg_edge && busy;
      if (state == IDLE && pg_edge)
        base_q <= page_sel ? 16'(PAGE0_BASE) : 16'(PAGE1_BASE);
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      iss_w   <= '0;
      iss_l   <= '0;
      iss_z   <= '0;
    end else begin
      rd_en <= issue_fire;
      if (state == IDLE) begin
        iss_w <= '0;
        iss_l <= '0;
        iss_z <= '0;
      end else if (issue_fire) begin
        rd_addr <= addr_calc;
        if (iss_w == WW'(WPZ - 1)) begin
          iss_w <= '0;
          if (iss_l == LW'(ZONE_H - 1)) begin
            iss_l <= '0;
            iss_z <= iss_z + 5'd1;
          end else begin
            iss_l <= iss_l + LW'(1);
          end
        end else begin
          iss_w <= iss_w + WW'(1);
        end
      end
    end
  end

  // Return side: counters mirror the request order and only move on data.
  logic [WW-1:0] ret_w;
  logic [LW-1:0] ret_l;
  logic [4:0]    ret_z;
  logic          ret_fire;
  assign ret_fire = rd_valid && (state != IDLE);

  logic        s1_valid;
  logic [47:0] s1_data;
  logic        s1_first;
  logic        s1_last;
  logic [4:0]  s1_zone;

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_w    <= '0;
      ret_l    <= '0;
      ret_z    <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_zone  <= '0;
    end else begin
      s1_valid <= ret_fire;
      if (state == IDLE) begin
        ret_w <= '0;
        ret_l <= '0;
        ret_z <= '0;
      end else if (ret_fire) begin
        s1_data  <= rd_data;
        s1_first <= (ret_w == '0) && (ret_l == '0);
        s1_last  <= (ret_w == WW'(WPZ - 1)) && (ret_l == LW'(ZONE_H - 1));
        s1_zone  <= ret_z;
        if (ret_w == WW'(WPZ - 1)) begin
          ret_w <= '0;
          if (ret_l == LW'(ZONE_H - 1)) begin
            ret_l <= '0;
            ret_z <= (ret_z == 5'(ZONES_X - 1)) ? 5'd0 : ret_z + 5'd1;
          end else begin
            ret_l <= ret_l + LW'(1);
          end
        end else begin
          ret_w <= ret_w + WW'(1);
        end
      end
    end
  end

  // Stage 2: per-word reduction folded into the zone accumulators.
  logic [7:0]  w_max;
  logic [10:0] w_sum;
  logic [7:0]  acc_max, new_max;
  logic [16:0] acc_sum, new_sum;

  always_comb begin
    w_max = 8'd0;
    w_sum = 11'd0;
    for (int i = 0; i < 6; i++) begin
      if (s1_data[8*i +: 8] > w_max) w_max = s1_data[8*i +: 8];
      w_sum = w_sum + 11'(s1_data[8*i +: 8]);
    end
    if (s1_first) begin
      new_max = w_max;
      new_sum = 17'(w_sum);
    end else begin
      new_max = (w_max > acc_max) ? w_max : acc_max;
      new_sum = acc_sum + 17'(w_sum);
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max    <= '0;
      acc_sum    <= '0;
      zone_valid <= 1'b0;
      zone_idx   <= '0;
      zone_max   <= '0;
      zone_sum   <= '0;
      row_done   <= 1'b0;
    end else begin
      zone_valid <= 1'b0;
      row_done   <= 1'b0;
      if (s1_valid) begin
        acc_max <= new_max;
        acc_sum <= new_sum;
        if (s1_last) begin
          zone_valid <= 1'b1;
          zone_idx   <= s1_zone;
          zone_max   <= new_max;
          zone_sum   <= new_sum;
          row_done   <= (s1_zone == 5'(ZONES_X - 1));
        end
      end
    end
  end

endmodule

// File: doc/zone_stat_rd.md
Name: zone_stat_rd

Overview:
- Downstream consumer of the block-row buffer filled by the pixel-packing write stage.
- On each page_sel edge it reads back the page the writer has just finished. It unpacks the 48-bit words into 8-bit gray pixels.
- It accumulates per-zone max and sum for one row of MiniLED backlight zones, then hands the per-zone statistics to the dimming stage.

Parameters:
- PAGE0_BASE, 1, start word address of page 0
- PAGE1_BASE, 11449, start word address of page 1
- ZONES_X, 26, zones per zone-row
- ZONE_H, 9, pixel lines per zone-row
- WPZ, 8, 48-bit words per zone per line (6 pixels/word, so 48 pixels wide)
- WPL, 208, words per line in page (must equal ZONES_X*WPZ)

Ports:
- i_pix_clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- page_sel  in  1  writer page flag; rising edge = page 0 complete, falling edge = page 1 complete
- rd_ready  in  1  memory accepts a read request this cycle (arbitrated against writer)
- rd_valid  in  1  rd_data valid; returns in request order, any latency ≥1
- rd_data  in  48  packed pixels; [47:40] = first pixel … [7:0] = sixth pixel
- rd_en  out  1  read request strobe
- rd_addr  out  16  read word address
- busy  out  1  pass in progress
- zone_valid  out  1  one-cycle strobe, zone result valid
- zone_idx  out  5  zone number 0..ZONES_X-1
- zone_max  out  8  max pixel in zone
- zone_sum  out  17  sum of 432 pixels (max 110160)
- row_done  out  1  one-cycle strobe after last zone of pass
- err_ovr  out  1  one-cycle strobe: page_sel edge while busy

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, page_sel edge-detect register loaded with current page_sel (no spurious edge after reset).
- Edge detect: page_sel registered once. Edge = registered value differs from the live input. base = PAGE0_BASE on rising edge, PAGE1_BASE on falling edge.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE on edge. busy=1 from the next cycle.
  - ISSUE→DRAIN after the last request is issued.
  - DRAIN→IDLE in the cycle row_done pulses. busy=0 from the following cycle.
- Read order is zone-major: for z in 0..ZONES_X-1, for l in 0..ZONE_H-1, for w in 0..WPZ-1.
  - rd_addr = base + l*WPL + z*WPZ + w.
  - Total 1872 requests per pass.
- Issue: in ISSUE, on each cycle with rd_ready=1, register rd_en=1 and rd_addr; advance the w/l/z counters.
  - rd_ready=0 gives rd_en=0 next cycle; rd_addr holds.
  - rd_en is never asserted outside ISSUE.
- Return side: independent return counters track w/l/z of incoming words; they advance only on rd_valid.
- Pipeline stage 1: register the word on rd_valid, plus flags first_of_zone and last_of_zone.
- Pipeline stage 2: compute the 6-byte max (8b) and 6-byte sum (11b).
  - On first_of_zone: load the accumulators.
  - Otherwise: acc_max = max(acc_max, wmax); acc_sum += wsum (17b, no overflow possible).
- Output: zone_valid, zone_idx, zone_max, zone_sum appear exactly 2 cycles after the rd_valid carrying the zone's last word.
  - Outputs hold until the next zone_valid.
  - row_done coincides with zone_valid of zone ZONES_X-1.
- Overrun: a page_sel edge while busy=1 pulses err_ovr the next cycle. The edge is discarded; the current pass continues unchanged.
- Edge in the same cycle row_done pulses: treated as busy, so err_ovr.
- Address arithmetic is 16-bit unsigned; the last page1 address is 11449+8*208+25*8+7 = 13320, with no wrap.
- Reset mid-pass: immediate return to IDLE, all strobes 0. Any rd_valid still in flight after reset is ignored (return counters inactive in IDLE).

Test Plan:
- Reset, then page_sel 0→1 with rd_ready=1 and a 3-cycle-latency memory model returning all bytes 0x10.
  - First rd_addr = 1, second = 2; word 8 (l=1) has rd_addr = 209.
  - 26 zone_valid strobes, each zone_max=0x10, zone_sum=6912; row_done coincides with zone 25.
- Memory contents = (addr mod 256) byte-replicated, read from page 1 (page_sel 1→0).
  - First rd_addr = 11449.
  - zone_idx 0 has zone_max = max over its 72 addresses; zone_sum matches a reference model.
  - Final rd_addr = 13320.
- rd_ready toggled in a random 50% pattern.
  - Exactly 1872 rd_en pulses; address sequence and results identical to the stall-free run.
  - rd_en never 1 one cycle after rd_ready=0.
- Zone 3 contains one pixel 0xFF in line 8, byte [7:0], all else 0x00.
  - zone 3 gives zone_max=0xFF, zone_sum=255; all other zones give 0/0.
- Second page_sel edge 100 cycles into a pass.
  - err_ovr pulses once; pass completes with 26 results; busy drops; no second pass starts.
- rst_n low mid-DRAIN, then a new edge.
  - All outputs 0 during reset; no zone_valid from the aborted pass; the fresh pass produces correct results.
